// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and helper functions for the sequential multiplier
package seq_mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  // prod holds the 2*w-bit product zero-extended to 64 bits.
  function automatic logic calc_overflow(input logic [63:0] prod, input int w, input logic sgn);
    logic ovf;
    ovf = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i >= w && i < 2 * w) begin
        if (sgn) ovf = ovf | (prod[i] != prod[w-1]);
        else     ovf = ovf | prod[i];
      end
    end
    return ovf;
  endfunction

  // Result is right-aligned in w bits; callers truncate to their width.
  function automatic logic [31:0] sat_value(input int w, input logic sgn, input logic negative);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF >> (32 - w);
    if (!sgn)          return ones;
    else if (negative) return ones ^ (ones >> 1);
    else               return ones >> 1;
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// rtl/seq_mult_datapath.sv - shift-add accumulator with final conditional negate
module seq_mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 neg,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   final_product
);

  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] acc_next;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH:0]   upper_sum;

  always_comb begin
    upper_sum = acc_q[2*WIDTH:WIDTH];
    if (mplier_q[0]) upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    acc_next = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
  end

  // Negating zero yields zero, so no special case is needed for a zero magnitude.
  assign final_product = (2*WIDTH)'(neg ? -acc_next : acc_next);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= mcand;
      mplier_q <= mplier;
    end else if (step) begin
      acc_q    <= acc_next;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/twos_complementor.sv
// rtl/twos_complementor.sv - conditional two's-complement negation
module twos_complementor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic             en,
  output logic [WIDTH-1:0] y
);

  assign y = en ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/seq_signed_multiplier.sv
// rtl/seq_signed_multiplier.sv - multi-cycle signed/unsigned multiplier (option: SEQ_SIGNED_MULTIPLIER_SATURATE_EN)
module seq_signed_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     product_narrow,
  output logic                 overflow
);

  mult_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic               signed_q;
  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] final_product;
  logic               final_ovf;
  logic [WIDTH-1:0]   final_narrow;

  twos_complementor #(.WIDTH(WIDTH)) u_mag_a (
    .x  (a),
    .en (is_signed & a[WIDTH-1]),
    .y  (a_mag)
  );

  twos_complementor #(.WIDTH(WIDTH)) u_mag_b (
    .x  (b),
    .en (is_signed & b[WIDTH-1]),
    .y  (b_mag)
  );

  seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (accept),
    .step          (state_q == CALC),
    .neg           (neg_q),
    .mcand         (a_mag),
    .mplier        (b_mag),
    .final_product (final_product)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign last_iter = (state_q == CALC) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign final_ovf = calc_overflow(64'(final_product), WIDTH, signed_q);

`ifdef SEQ_SIGNED_MULTIPLIER_SATURATE_EN
  assign final_narrow = final_ovf
    ? WIDTH'(sat_value(WIDTH, signed_q, final_product[2*WIDTH-1]))
    : final_product[WIDTH-1:0];
`else
  assign final_narrow = final_product[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      neg_q          <= 1'b0;
      signed_q       <= 1'b0;
      product        <= '0;
      product_narrow <= '0;
      overflow       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= CNT_W'(WIDTH);
        neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        signed_q <= is_signed;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Results only change on completion; they persist through DONE and IDLE.
      if (last_iter) begin
        product        <= final_product;
        product_narrow <= final_narrow;
        overflow       <= final_ovf;
      end
    end
  end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// tb/tb_seq_signed_multiplier.sv - directed self-checking bench for seq_signed_multiplier
module tb_seq_signed_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           is_signed;
  logic [W-1:0]   a, b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic [W-1:0]   product_narrow;
  logic           overflow;

  int vectors = 0;
  int errors  = 0;

  seq_signed_multiplier #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .is_signed      (is_signed),
    .a              (a),
    .b              (b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .product        (product),
    .product_narrow (product_narrow),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single accept edge, then counts edges until out_valid (-1 on timeout).
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic sg, output int lat);
    a = va; b = vb; is_signed = sg; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'h5A; b = 8'hA5; is_signed = ~sg;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    vectors++;
    if ({in_ready, out_valid, product, product_narrow, overflow} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b product=%h narrow=%h ovf=%b, required 1 0 0000 00 0",
               in_ready, out_valid, product, product_narrow, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_products();
    logic [W-1:0]   ta [10] = '{8'hFD, 8'h80, 8'hFF, 8'hFF, 8'h64, 8'h9C, 8'h00, 8'h0F, 8'h10, 8'h07};
    logic [W-1:0]   tb [10] = '{8'h05, 8'h80, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'hF9, 8'h11, 8'h10, 8'h09};
    logic           ts [10] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    logic [2*W-1:0] tp [10] = '{16'hFFF1, 16'h4000, 16'hFE01, 16'h0001, 16'h00C8,
                                16'hFF38, 16'h0000, 16'h00FF, 16'h0100, 16'h003F};
    logic           tv [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SEQ_SIGNED_MULTIPLIER_SATURATE_EN
    logic [W-1:0]   tn [10] = '{8'hF1, 8'h7F, 8'hFF, 8'h01, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h3F};
`else
    logic [W-1:0]   tn [10] = '{8'hF1, 8'h00, 8'h01, 8'h01, 8'hC8, 8'h38, 8'h00, 8'hFF, 8'h00, 8'h3F};
`endif
    int lat;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_before_op%0d: in_ready=%b required 1", i, in_ready);
      end
      issue(ta[i], tb[i], ts[i], lat);
      vectors++;
      if (lat !== W) begin
        errors++;
        $display("FAIL latency_op%0d: got %0d cycles required %0d", i, lat, W);
      end
      vectors++;
      if ({product, overflow, product_narrow} !== {tp[i], tv[i], tn[i]}) begin
        errors++;
        $display("FAIL result_op%0d (%h x %h s=%b): product=%h ovf=%b narrow=%h, required %h %b %h",
                 i, ta[i], tb[i], ts[i], product, overflow, product_narrow, tp[i], tv[i], tn[i]);
      end
      release_result();
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    issue(8'h07, 8'h09, 1'b1, lat);
    vectors++;
    if (lat !== W || product !== 16'h003F) begin
      errors++;
      $display("FAIL bp_setup: lat=%0d product=%h, required %0d 003f", lat, product, W);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0]; a = 8'h33; b = 8'h44; is_signed = 1'b0;
      tick();
      vectors++;
      if ({out_valid, in_ready, product, overflow, product_narrow} !== {1'b1, 1'b0, 16'h003F, 1'b0, 8'h3F}) begin
        errors++;
        $display("FAIL bp_hold_cycle%0d: out_valid=%b in_ready=%b product=%h ovf=%b narrow=%h, required 1 0 003f 0 3f",
                 i, out_valid, in_ready, product, overflow, product_narrow);
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if ({out_valid, in_ready, product} !== {1'b0, 1'b1, 16'h003F}) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b product=%h, required 0 1 003f", out_valid, in_ready, product);
    end
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_accept: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    a = 8'h0B; b = 8'h0D; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, in_ready, product, overflow} !== {1'b0, 1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_calc: out_valid=%b in_ready=%b product=%h ovf=%b, required 0 1 0000 0",
               out_valid, in_ready, product, overflow);
    end
    issue(8'h0C, 8'hF5, 1'b1, lat);
    vectors++;
`ifdef SEQ_SIGNED_MULTIPLIER_SATURATE_EN
    if ({product, overflow, product_narrow} !== {16'hFF7C, 1'b1, 8'h80} || lat !== W) begin
`else
    if ({product, overflow, product_narrow} !== {16'hFF7C, 1'b1, 8'h7C} || lat !== W) begin
`endif
      errors++;
      $display("FAIL after_reset_op: lat=%0d product=%h ovf=%b narrow=%h, required %0d ff7c 1", lat, product, overflow, product_narrow, W);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_products();
    test_back_pressure();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
